// File: rtl/aes_dec_pkg.sv
// Shared types and widths for the AES-256 decryption datapath.
package aes_dec_pkg;

    localparam int unsigned AES_STATE_W = 128;
    localparam int unsigned AES_BYTES   = 16;

    typedef logic [7:0] aes_byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        HOLD = 2'd2
    } inv_sb_state_t;

endpackage

// File: rtl/inv_sub_bytes_iter_sbox.sv
// InverseSbox: 8-bit combinational AES inverse S-box lookup.
module InverseSbox
    import aes_dec_pkg::*;
(
    input  aes_byte_t i_byte,
    output aes_byte_t o_byte
);

    // Row r holds the inverse of bytes 8'hr0..8'hrf; index 0 is the leftmost byte.
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign o_byte = INV_SBOX[i_byte];

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative InvSubBytes: substitutes LANES bytes of the round state per cycle.
module inv_sub_bytes_iter
    import aes_dec_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state,
    output logic                   busy
);

    localparam int unsigned STEPS = AES_BYTES / LANES;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned IDX_W = $clog2(AES_BYTES);

    // Only power-of-two lane counts divide the state evenly.
    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("inv_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    inv_sb_state_t                   r_state;
    inv_sb_state_t                   w_state_nxt;
    logic [CNT_W-1:0]                r_cnt;
    logic [CNT_W-1:0]                w_cnt_nxt;
    aes_byte_t [0:AES_BYTES-1]       r_work;
    aes_byte_t [0:AES_BYTES-1]       w_work_nxt;
    logic                            r_in_ready;
    logic                            r_out_valid;
    logic                            r_busy;
    logic                            w_accept;
    logic                            w_last;
    logic [IDX_W-1:0]                w_idx    [LANES];
    aes_byte_t                       w_sb_in  [LANES];
    aes_byte_t                       w_sb_out [LANES];

    assign w_accept = in_valid && r_in_ready;
    assign w_last   = (r_cnt == CNT_W'(STEPS - 1));

    // Per-lane byte mux into the S-box; the write-back uses the same index.
    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            assign w_idx[l]   = IDX_W'(32'(r_cnt) * LANES + 32'(l));
            assign w_sb_in[l] = r_work[w_idx[l]];

            InverseSbox u_sbox (
                .i_byte (w_sb_in[l]),
                .o_byte (w_sb_out[l])
            );
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, counter and in-place working-register update.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_work_nxt  = r_work;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_work_nxt  = in_state;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SUB;
                end
            end
            SUB: begin
                for (int l = 0; l < LANES; l++) begin
                    w_work_nxt[w_idx[l]] = w_sb_out[l];
                end
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (w_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath and handshake flags, registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_work      <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_work      <= w_work_nxt;
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == HOLD);
            r_busy      <= (w_state_nxt != IDLE);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out_state = r_work;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Directed self-checking bench for inv_sub_bytes_iter (LANES=4 plus a LANES sweep).
module tb_inv_sub_bytes_iter;

    localparam logic [127:0] ID_IN  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] ID_OUT = 128'h52096ad53036a538bf40a39e81f3d7fb;
    localparam logic [127:0] S63_IN = {16{8'h63}};
    localparam logic [127:0] S63_OUT = {16{8'h00}};
    localparam logic [127:0] S16_IN = {16{8'h16}};
    localparam logic [127:0] S16_OUT = {16{8'hff}};
    localparam logic [127:0] B_IN  = {8{16'h6316}};
    localparam logic [127:0] B_OUT = {8{16'h00ff}};

    localparam int SW_N = 4;
    localparam int unsigned SW_L [SW_N] = '{1, 2, 8, 16};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    logic [SW_N-1:0] sw_in_valid;
    logic [SW_N-1:0] sw_in_ready;
    logic [SW_N-1:0] sw_out_valid;
    logic [SW_N-1:0] sw_busy;
    logic            sw_out_ready;
    logic [127:0]    sw_out_state [SW_N];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    inv_sub_bytes_iter #(.LANES(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    generate
        for (genvar g = 0; g < SW_N; g++) begin : g_sw
            inv_sub_bytes_iter #(.LANES(SW_L[g])) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (sw_in_valid[g]),
                .in_ready  (sw_in_ready[g]),
                .in_state  (in_state),
                .out_valid (sw_out_valid[g]),
                .out_ready (sw_out_ready),
                .out_state (sw_out_state[g]),
                .busy      (sw_busy[g])
            );
        end
    endgenerate

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction on the LANES=4 instance with out_ready held high.
    task automatic run_vec(input string tag, input logic [127:0] v, input logic [127:0] exp);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin tick(); n++; end
        chk({tag, "_rdy"}, 128'(in_ready), 128'(1));
        in_state = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_state = ~v;
        chk({tag, "_busy"}, 128'(busy), 128'(1));
        n = 0;
        while (!out_valid && n < 40) begin tick(); n++; end
        chk({tag, "_lat"}, 128'(n), 128'(4));
        chk({tag, "_data"}, out_state, exp);
        tick();
        chk({tag, "_drop"}, 128'(out_valid), 128'(0));
    endtask

    initial begin
        int n;
        int acc;
        int xfr;
        int cyc;
        logic [127:0] b2b_exp [2];

        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_state     = '0;
        out_ready    = 1'b1;
        sw_in_valid  = '0;
        sw_out_ready = 1'b1;
        b2b_exp[0]   = ID_OUT;
        b2b_exp[1]   = B_OUT;

        // Reset values
        #2;
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_out_state", out_state, 128'h0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_low", 128'(in_ready), 128'(0));
        tick();
        chk("rel_in_ready_high", 128'(in_ready), 128'(1));

        // Directed vectors
        run_vec("ident", ID_IN, ID_OUT);
        run_vec("s63", S63_IN, S63_OUT);
        run_vec("s16", S16_IN, S16_OUT);

        // Backpressure in HOLD
        out_ready = 1'b0;
        in_state  = ID_IN;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        in_state  = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        n = 0;
        while (!out_valid && n < 40) begin tick(); n++; end
        chk("bp_lat", 128'(n), 128'(4));
        chk("bp_data", out_state, ID_OUT);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bp_valid", 128'(out_valid), 128'(1));
            chk("bp_stable", out_state, ID_OUT);
            chk("bp_in_ready", 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
        tick();
        chk("bp_xfer_valid", 128'(out_valid), 128'(0));
        chk("bp_xfer_in_ready", 128'(in_ready), 128'(1));

        // Back-to-back with in_valid held high
        acc = 0;
        xfr = 0;
        cyc = 0;
        while (xfr < 2 && cyc < 60) begin
            in_valid = (acc < 2);
            in_state = (acc == 0) ? ID_IN : B_IN;
            if (in_valid && in_ready) begin
                chk("b2b_order", 128'(xfr), 128'(acc));
                acc++;
            end
            if (out_valid && out_ready) begin
                chk("b2b_data", out_state, b2b_exp[xfr]);
                xfr++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        chk("b2b_count", 128'(xfr), 128'(2));
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("b2b_no_extra", 128'(out_valid), 128'(0));
        end

        // Reset two cycles into SUB
        in_state = ID_IN;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_in_ready", 128'(in_ready), 128'(0));
        chk("mid_rst_out_state", out_state, 128'h0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("mid_rst_no_stale", 128'(out_valid), 128'(0));
        end
        run_vec("post_rst", ID_IN, ID_OUT);

        // LANES sweep
        for (int g = 0; g < SW_N; g++) begin
            n = 0;
            while (!sw_in_ready[g] && n < 40) begin tick(); n++; end
            chk("sweep_rdy", 128'(sw_in_ready[g]), 128'(1));
            in_state       = ID_IN;
            sw_in_valid[g] = 1'b1;
            tick();
            sw_in_valid[g] = 1'b0;
            in_state       = '0;
            n = 0;
            while (!sw_out_valid[g] && n < 40) begin tick(); n++; end
            chk("sweep_lat", 128'(n), 128'(16 / SW_L[g]));
            chk("sweep_data", sw_out_state[g], ID_OUT);
            tick();
            chk("sweep_drop", 128'(sw_out_valid[g]), 128'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
